// File: rtl/motion_pkg.sv
// Shared types and default parameter values for the falling-ball motion engine.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } motion_state_t;

  localparam int          DEF_X_W         = 10;
  localparam int          DEF_Y_W         = 26;
  localparam int          DEF_X_MIN       = 0;
  localparam int          DEF_X_MAX       = 400;
  localparam int          DEF_X_INIT      = 164;
  localparam int unsigned DEF_Y_MAX       = 32'd67108863;
  localparam int          DEF_TICK_DIV    = 65536;
  localparam int          DEF_MAX_SPEED   = 4;
  localparam int          DEF_ACCEL_TICKS = 8;

endpackage

// File: rtl/motion_ctrl_if.sv
// Button/command inputs and position/status outputs of the motion engine.
interface motion_ctrl_if #(
  parameter int X_W = 10,
  parameter int Y_W = 26
);

  logic           left;
  logic           right;
  logic           pause;
  logic           recenter;
  logic [X_W-1:0] x_pos;
  logic [Y_W-1:0] y_pos;
  logic           tick;
  logic           at_left;
  logic           at_right;
  logic           moving;

  // Controller side: drives buttons, observes position and status.
  modport master (
    output left, right, pause, recenter,
    input  x_pos, y_pos, tick, at_left, at_right, moving
  );

  // Engine side.
  modport slave (
    input  left, right, pause, recenter,
    output x_pos, y_pos, tick, at_left, at_right, moving
  );

endinterface

// File: rtl/motion_ctrl_tick_prescaler.sv
// Free-running divider producing a one-cycle movement tick every TICK_DIV cycles.
module tick_prescaler
  import motion_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clkdiv,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; restart from 0 on reset.
  always_ff @(posedge clkdiv or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motion_ctrl.sv
// Position engine: synchronised buttons drive an IDLE/LEFT/RIGHT FSM with a
// speed ramp and clamped x; y is a pausable wrapping scroll counter.
module motion_ctrl
  import motion_pkg::*;
#(
  parameter int          X_W         = DEF_X_W,
  parameter int          Y_W         = DEF_Y_W,
  parameter int          X_MIN       = DEF_X_MIN,
  parameter int          X_MAX       = DEF_X_MAX,
  parameter int          X_INIT      = DEF_X_INIT,
  parameter int unsigned Y_MAX       = DEF_Y_MAX,
  parameter int          TICK_DIV    = DEF_TICK_DIV,
  parameter int          MAX_SPEED   = DEF_MAX_SPEED,
  parameter int          ACCEL_TICKS = DEF_ACCEL_TICKS
) (
  input  logic         clkdiv,
  input  logic         reset,
  motion_ctrl_if.slave bus
);

  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int RAMP_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [X_W-1:0]    X_MIN_V   = X_W'(X_MIN);
  localparam logic [X_W-1:0]    X_MAX_V   = X_W'(X_MAX);
  localparam logic [X_W-1:0]    X_INIT_V  = X_W'(X_INIT);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_MAX);
  localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0]  SPD_ONE   = SPD_W'(1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(ACCEL_TICKS - 1);

  // Clamp a one-bit-wider signed candidate back into [X_MIN, X_MAX].
  function automatic logic [X_W-1:0] clamp_x(input logic signed [X_W:0] v);
    logic signed [X_W:0] lo;
    logic signed [X_W:0] hi;
    lo = $signed({1'b0, X_MIN_V});
    hi = $signed({1'b0, X_MAX_V});
    if (v < lo) begin
      return X_MIN_V;
    end else if (v > hi) begin
      return X_MAX_V;
    end else begin
      return v[X_W-1:0];
    end
  endfunction

  // Next speed step, saturating at MAX_SPEED.
  function automatic logic [SPD_W-1:0] sat_spd(input logic [SPD_W-1:0] s);
    if (s >= SPD_MAX) begin
      return SPD_MAX;
    end else begin
      return s + 1'b1;
    end
  endfunction

  logic tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clkdiv (clkdiv),
    .reset  (reset),
    .tick   (tick)
  );

  // Button synchronisers: _p0 is the metastability catcher, _p1 is safe to use.
  logic left_p0, left_p1, right_p0, right_p1;
  logic l_s, r_s;

  // Two-flop synchronisers for the asynchronous buttons.
  always_ff @(posedge clkdiv or posedge reset) begin
    if (reset) begin
      left_p0  <= 1'b0;
      left_p1  <= 1'b0;
      right_p0 <= 1'b0;
      right_p1 <= 1'b0;
    end else begin
      left_p0  <= bus.left;
      left_p1  <= left_p0;
      right_p0 <= bus.right;
      right_p1 <= right_p0;
    end
  end

  assign l_s = left_p1;
  assign r_s = right_p1;

  // Motion state and datapath registers.
  motion_state_t     state, state_n;
  logic [SPD_W-1:0]  spd, spd_n;
  logic [RAMP_W-1:0] ramp, ramp_n;
  logic [X_W-1:0]    x_r, x_n;
  logic [Y_W-1:0]    y_r, y_n;
  logic              want_l, want_r;
  logic signed [X_W:0] x_wide, spd_wide;

  assign want_l   = l_s & ~r_s;
  assign want_r   = r_s & ~l_s;
  assign x_wide   = $signed({1'b0, x_r});
  assign spd_wide = $signed((X_W + 1)'(spd_n));

  // Next-state, speed ramp and x/y update; only tick edges or recenter move anything.
  always_comb begin
    state_n = state;
    spd_n   = spd;
    ramp_n  = ramp;
    x_n     = x_r;
    y_n     = y_r;

    if (bus.recenter) begin
      state_n = IDLE;
      spd_n   = '0;
      ramp_n  = '0;
      x_n     = X_INIT_V;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (want_l) begin
            state_n = LEFT;
            spd_n   = SPD_ONE;
            ramp_n  = '0;
          end else if (want_r) begin
            state_n = RIGHT;
            spd_n   = SPD_ONE;
            ramp_n  = '0;
          end
        end
        LEFT, RIGHT: begin
          if ((state == LEFT && want_l) || (state == RIGHT && want_r)) begin
            if (ramp == RAMP_LAST) begin
              ramp_n = '0;
              spd_n  = sat_spd(spd);
            end else begin
              ramp_n = ramp + 1'b1;
            end
          end else begin
            // Release, both buttons, or reversal: one idle tick with no movement.
            state_n = IDLE;
            spd_n   = '0;
            ramp_n  = '0;
          end
        end
        default: begin
          state_n = IDLE;
          spd_n   = '0;
          ramp_n  = '0;
        end
      endcase

      case (state_n)
        LEFT:    x_n = clamp_x(x_wide - spd_wide);
        RIGHT:   x_n = clamp_x(x_wide + spd_wide);
        default: x_n = x_r;
      endcase
    end

    if (tick && !bus.pause) begin
      y_n = (y_r == Y_LAST) ? '0 : y_r + 1'b1;
    end
  end

  // Register state, speed, ramp and positions.
  always_ff @(posedge clkdiv or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      spd   <= '0;
      ramp  <= '0;
      x_r   <= X_INIT_V;
      y_r   <= '0;
    end else begin
      state <= state_n;
      spd   <= spd_n;
      ramp  <= ramp_n;
      x_r   <= x_n;
      y_r   <= y_n;
    end
  end

  assign bus.x_pos    = x_r;
  assign bus.y_pos    = y_r;
  assign bus.tick     = tick;
  assign bus.at_left  = (x_r == X_MIN_V);
  assign bus.at_right = (x_r == X_MAX_V);
  assign bus.moving   = (state != IDLE);

endmodule

// File: tb/tb_motion_ctrl.sv
// Bench for motion_ctrl: directed button sequences, a behavioural model
// checked every cycle, and hand-computed literal expectations.
module tb_motion_ctrl;

  localparam int TD    = 4;
  localparam int MS    = 3;
  localparam int AT    = 2;
  localparam int XMIN  = 0;
  localparam int XMAX  = 20;
  localparam int XINIT = 10;
  localparam int YMAX  = 5;
  localparam int XW    = 6;
  localparam int YW    = 4;

  logic clkdiv = 1'b0;
  logic reset;

  always #5 clkdiv = ~clkdiv;

  motion_ctrl_if #(.X_W(XW), .Y_W(YW)) bus ();

  motion_ctrl #(
    .X_W         (XW),
    .Y_W         (YW),
    .X_MIN       (XMIN),
    .X_MAX       (XMAX),
    .X_INIT      (XINIT),
    .Y_MAX       (YMAX),
    .TICK_DIV    (TD),
    .MAX_SPEED   (MS),
    .ACCEL_TICKS (AT)
  ) dut (
    .clkdiv (clkdiv),
    .reset  (reset),
    .bus    (bus)
  );

  // Behavioural model: direction -1/0/+1, speed, ramp, prescale count, button pipes.
  int m_x = XINIT, m_y = 0, m_dir = 0, m_spd = 0, m_ramp = 0, m_cnt = 0;
  bit m_l1 = 0, m_l2 = 0, m_r1 = 0, m_r2 = 0;
  bit m_tick;
  int m_want;

  always @(posedge clkdiv or posedge reset) begin
    if (reset) begin
      m_x = XINIT; m_y = 0; m_dir = 0; m_spd = 0; m_ramp = 0; m_cnt = 0;
      m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0;
    end else begin
      m_tick = (m_cnt == TD - 1);
      m_want = (m_l2 && !m_r2) ? -1 : ((m_r2 && !m_l2) ? 1 : 0);
      m_l2 = m_l1; m_l1 = bus.left;
      m_r2 = m_r1; m_r1 = bus.right;
      if (bus.recenter) begin
        m_x = XINIT; m_dir = 0; m_spd = 0; m_ramp = 0;
      end else if (m_tick) begin
        if (m_dir == 0) begin
          if (m_want != 0) begin m_dir = m_want; m_spd = 1; m_ramp = 0; end
        end else if (m_want == m_dir) begin
          if (m_ramp == AT - 1) begin
            m_ramp = 0;
            m_spd = (m_spd + 1 > MS) ? MS : m_spd + 1;
          end else begin
            m_ramp = m_ramp + 1;
          end
        end else begin
          m_dir = 0; m_spd = 0; m_ramp = 0;
        end
        m_x = m_x + m_dir * m_spd;
        if (m_x < XMIN) m_x = XMIN;
        if (m_x > XMAX) m_x = XMAX;
      end
      if (m_tick && !bus.pause) m_y = (m_y == YMAX) ? 0 : m_y + 1;
      m_cnt = (m_cnt + 1) % TD;
    end
  end

  // Literal-expectation mailbox: main fills it, compare process consumes it.
  int    n_run = 0, n_fail = 0;
  int    lit_req = 0, lit_seen = 0;
  string lit_name;
  int    lit_act, lit_exp;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT vs model each cycle, plus any pending literal check.
  always @(negedge clkdiv) begin
    chk("x_pos",    int'(bus.x_pos),    m_x);
    chk("y_pos",    int'(bus.y_pos),    m_y);
    chk("tick",     int'(bus.tick),     (m_cnt == TD - 1) ? 1 : 0);
    chk("at_left",  int'(bus.at_left),  (m_x == XMIN) ? 1 : 0);
    chk("at_right", int'(bus.at_right), (m_x == XMAX) ? 1 : 0);
    chk("moving",   int'(bus.moving),   (m_dir != 0) ? 1 : 0);
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      chk(lit_name, lit_act, lit_exp);
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    lit_name = nm; lit_act = act; lit_exp = exp;
    lit_req++;
    @(negedge clkdiv); #1;
  endtask

  // Return #1 after the next tick edge (bounded).
  task automatic wait_tick_edge();
    int n;
    n = 0;
    do begin
      @(negedge clkdiv);
      n++;
    end while (bus.tick !== 1'b1 && n < 20);
    if (bus.tick !== 1'b1) begin
      $display("FAIL tick_timeout: no tick in %0d cycles, required one every %0d", n, TD);
      $fatal(1, "tick timeout");
    end
    @(posedge clkdiv); #1;
  endtask

  // Edges from reset release to the first tick edge.
  task automatic edges_to_tick(output int n);
    logic t;
    n = 0;
    do begin
      @(negedge clkdiv);
      t = bus.tick;
      @(posedge clkdiv);
      n++;
    end while (t !== 1'b1 && n < 20);
    #1;
  endtask

  initial begin
    int xs[8];
    int ys[8];
    int mv[8];
    int ar[8];
    int n, tk;
    int x_exp_r[7] = '{11, 12, 14, 16, 19, 20, 20};
    int y_exp_i[6] = '{1, 2, 3, 4, 5, 0};

    bus.left = 0; bus.right = 0; bus.pause = 0; bus.recenter = 0;
    reset = 1'b1;
    repeat (3) @(posedge clkdiv);
    #1;

    // Reset values
    lit("rst_x",        int'(bus.x_pos),    10);
    lit("rst_y",        int'(bus.y_pos),    0);
    lit("rst_tick",     int'(bus.tick),     0);
    lit("rst_moving",   int'(bus.moving),   0);
    lit("rst_at_left",  int'(bus.at_left),  0);
    lit("rst_at_right", int'(bus.at_right), 0);

    // Idle run: x fixed, y 1..5 then wrap
    @(posedge clkdiv); #1;
    reset = 1'b0;
    edges_to_tick(n);
    ys[0] = bus.y_pos; xs[0] = bus.x_pos;
    for (int i = 1; i < 6; i++) begin
      wait_tick_edge();
      ys[i] = bus.y_pos; xs[i] = bus.x_pos;
    end
    lit("first_tick_edges", n, 4);
    for (int i = 0; i < 6; i++) lit($sformatf("idle_y%0d", i), ys[i], y_exp_i[i]);
    lit("idle_x", xs[5], 10);

    // Hold right: ramp and clamp at X_MAX
    wait_tick_edge();
    bus.right = 1;
    for (int i = 0; i < 7; i++) begin
      wait_tick_edge();
      xs[i] = bus.x_pos; mv[i] = bus.moving; ar[i] = bus.at_right;
    end
    for (int i = 0; i < 7; i++) lit($sformatf("right_x%0d", i), xs[i], x_exp_r[i]);
    lit("right_moving0", mv[0], 1);
    lit("right_moving6", mv[6], 1);
    lit("right_at_right3", ar[3], 0);
    lit("right_at_right6", ar[6], 1);

    // Recenter between ticks
    wait_tick_edge();
    bus.right = 0; bus.recenter = 1;
    @(posedge clkdiv); #1;
    bus.recenter = 0;
    xs[0] = bus.x_pos; mv[0] = bus.moving;
    lit("recenter_x", xs[0], 10);
    lit("recenter_moving", mv[0], 0);

    // Hold left, then add right: both pressed reads as release
    wait_tick_edge();
    bus.left = 1;
    for (int i = 0; i < 3; i++) begin
      wait_tick_edge();
      xs[i] = bus.x_pos; mv[i] = bus.moving;
    end
    bus.right = 1;
    wait_tick_edge();
    xs[3] = bus.x_pos; mv[3] = bus.moving;
    lit("both_x0", xs[0], 9);
    lit("both_x1", xs[1], 8);
    lit("both_x2", xs[2], 6);
    lit("both_x3", xs[3], 6);
    lit("both_moving2", mv[2], 1);
    lit("both_moving3", mv[3], 0);

    // Reversal left -> right passes through one idle tick
    wait_tick_edge();
    bus.right = 0;
    wait_tick_edge();
    xs[0] = bus.x_pos;
    bus.left = 0; bus.right = 1;
    wait_tick_edge();
    xs[1] = bus.x_pos; mv[1] = bus.moving;
    wait_tick_edge();
    xs[2] = bus.x_pos; mv[2] = bus.moving;
    bus.right = 0;
    lit("rev_x0", xs[0], 5);
    lit("rev_x1", xs[1], 5);
    lit("rev_moving1", mv[1], 0);
    lit("rev_x2", xs[2], 6);
    lit("rev_moving2", mv[2], 1);

    // Pause freezes y only; recenter on a tick cycle
    reset = 1'b1;
    @(posedge clkdiv); #1;
    reset = 1'b0;
    wait_tick_edge();
    ys[0] = bus.y_pos; xs[0] = bus.x_pos;
    bus.right = 1; bus.pause = 1;
    for (int i = 1; i < 3; i++) begin
      wait_tick_edge();
      ys[i] = bus.y_pos; xs[i] = bus.x_pos;
    end
    bus.pause = 0;
    wait_tick_edge();
    ys[3] = bus.y_pos; xs[3] = bus.x_pos;
    repeat (3) @(posedge clkdiv);
    #1;
    tk = bus.tick;
    bus.recenter = 1;
    @(posedge clkdiv); #1;
    bus.recenter = 0;
    xs[4] = bus.x_pos; ys[4] = bus.y_pos; mv[4] = bus.moving;
    lit("pause_y0", ys[0], 1);
    lit("pause_y1", ys[1], 1);
    lit("pause_y2", ys[2], 1);
    lit("pause_y3", ys[3], 2);
    lit("pause_x1", xs[1], 11);
    lit("pause_x2", xs[2], 12);
    lit("pause_x3", xs[3], 14);
    lit("rc_tick_cycle", tk, 1);
    lit("rc_tick_x", xs[4], 10);
    lit("rc_tick_y", ys[4], 3);
    lit("rc_tick_moving", mv[4], 0);

    // Reset mid-ramp, between ticks
    wait_tick_edge();
    wait_tick_edge();
    @(posedge clkdiv); #1;
    reset = 1'b1;
    #1;
    xs[0] = bus.x_pos; ys[0] = bus.y_pos; tk = bus.tick;
    mv[0] = bus.moving; ar[0] = bus.at_right; ar[1] = bus.at_left;
    bus.right = 0;
    @(posedge clkdiv); #1;
    reset = 1'b0;
    edges_to_tick(n);
    lit("mid_rst_x", xs[0], 10);
    lit("mid_rst_y", ys[0], 0);
    lit("mid_rst_tick", tk, 0);
    lit("mid_rst_moving", mv[0], 0);
    lit("mid_rst_at_right", ar[0], 0);
    lit("mid_rst_at_left", ar[1], 0);
    lit("mid_rst_tick_edges", n, 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
